// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory-access and writeback stage with req/ack data memory port
module mem_wb_stage #(
  parameter int N          = 32,
  parameter int MEM_ADDR_W = 16,
  parameter int ADDR_BASE  = 1024,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WB_ENIn,
  input  logic                  MEM_R_ENIn,
  input  logic                  MEM_W_ENIn,
  input  logic [3:0]            DestIn,
  input  logic [N-1:0]          ALU_ResIn,
  input  logic [N-1:0]          Val_RmIn,
  output logic                  memReqOut,
  output logic                  memWeOut,
  output logic [MEM_ADDR_W-1:0] memAddrOut,
  output logic [N-1:0]          memWDataOut,
  input  logic [N-1:0]          memRDataIn,
  input  logic                  memAckIn,
  output logic                  freezeOut,
  output logic                  WB_ENOut,
  output logic [3:0]            WB_DestOut,
  output logic [N-1:0]          WB_ValueOut,
  output logic                  errOut
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [N-1:0]          wdata_q, wdata_d;
  logic                  wb_en_q, wb_en_d;
  logic [3:0]            wb_dest_q, wb_dest_d;
  logic [N-1:0]          wb_value_q, wb_value_d;
  logic                  err_q, err_d;
  logic [3:0]            lat_dest_q, lat_dest_d;
  logic                  lat_wb_q, lat_wb_d;

  logic                  mem_op;
  logic                  cnt_expired;
  logic [N-1:0]          byte_off;
  logic [MEM_ADDR_W-1:0] word_addr;

  assign mem_op      = MEM_R_ENIn | MEM_W_ENIn;
  assign cnt_expired = (cnt_q == CNT_LAST);
  // Byte offset from the memory window base wraps modulo 2^N; low two bits are dropped.
  assign byte_off    = ALU_ResIn - N'(ADDR_BASE);
  assign word_addr   = MEM_ADDR_W'(byte_off >> 2);

  // Next-state: issue from IDLE, retire on ack or abandon on timeout in WAIT.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wb_en_d    = wb_en_q;
    wb_dest_d  = wb_dest_q;
    wb_value_d = wb_value_q;
    err_d      = err_q;
    lat_dest_d = lat_dest_q;
    lat_wb_d   = lat_wb_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          state_d    = ST_WAIT;
          cnt_d      = '0;
          req_d      = 1'b1;
          // A simultaneous read and write request is treated as a store.
          we_d       = MEM_W_ENIn;
          addr_d     = word_addr;
          wdata_d    = Val_RmIn;
          lat_dest_d = DestIn;
          lat_wb_d   = WB_ENIn;
          wb_en_d    = 1'b0;
        end else begin
          wb_en_d    = WB_ENIn;
          wb_dest_d  = DestIn;
          wb_value_d = ALU_ResIn;
        end
      end
      ST_WAIT: begin
        wb_en_d = 1'b0;
        if (memAckIn) begin
          // Ack wins over a coinciding timeout, so errOut is left alone here.
          state_d = ST_IDLE;
          req_d   = 1'b0;
          cnt_d   = '0;
          if (!we_q) begin
            wb_en_d    = lat_wb_q;
            wb_dest_d  = lat_dest_q;
            wb_value_d = memRDataIn;
          end
        end else if (cnt_expired) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        wb_en_d = 1'b0;
      end
    endcase
  end

  // Upstream stall: held while an access is pending, released in the ack or expiry cycle.
  always_comb begin
    freezeOut = 1'b0;
    if (!rst) begin
      if (state_q == ST_IDLE) begin
        freezeOut = mem_op;
      end else begin
        freezeOut = !memAckIn && !cnt_expired;
      end
    end
  end

  // State and output registers; reset abandons any outstanding access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wb_en_q    <= 1'b0;
      wb_dest_q  <= '0;
      wb_value_q <= '0;
      err_q      <= 1'b0;
      lat_dest_q <= '0;
      lat_wb_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wb_en_q    <= wb_en_d;
      wb_dest_q  <= wb_dest_d;
      wb_value_q <= wb_value_d;
      err_q      <= err_d;
      lat_dest_q <= lat_dest_d;
      lat_wb_q   <= lat_wb_d;
    end
  end

  assign memReqOut   = req_q;
  assign memWeOut    = we_q;
  assign memAddrOut  = addr_q;
  assign memWDataOut = wdata_q;
  assign WB_ENOut    = wb_en_q;
  assign WB_DestOut  = wb_dest_q;
  assign WB_ValueOut = wb_value_q;
  assign errOut      = err_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access and writeback stage of the ARM pipeline.
- Takes EXE-stage results, performs data-memory loads/stores over a req/ack handshake, and drives the register-file write port (WB_EN/WB_Dest/WB_Value) consumed by the decode stage.
- Raises freezeOut to hold all upstream stages while a memory access is outstanding.

Parameters:
- N, 32, datapath width.
- MEM_ADDR_W, 16, word-address width toward data memory.
- ADDR_BASE, 1024, byte address mapped to memory word 0.
- TIMEOUT, 64, max WAIT cycles before an access is abandoned (must be ≥ 1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- WB_ENIn  input  1  instruction writes a register.
- MEM_R_ENIn  input  1  load.
- MEM_W_ENIn  input  1  store.
- DestIn  input  4  destination register.
- ALU_ResIn  input  N  ALU result / effective byte address.
- Val_RmIn  input  N  store data.
- memReqOut  output  1  access request to data memory.
- memWeOut  output  1  1 = write, 0 = read.
- memAddrOut  output  MEM_ADDR_W  word address.
- memWDataOut  output  N  write data.
- memRDataIn  input  N  read data, valid when memAckIn = 1.
- memAckIn  input  1  access complete.
- freezeOut  output  1  stall upstream pipeline.
- WB_ENOut  output  1  register-file write enable.
- WB_DestOut  output  4  register-file write address.
- WB_ValueOut  output  N  register-file write data.
- errOut  output  1  sticky flag: an access timed out.

Behaviour:
- Reset (rst = 1 at an edge): state IDLE, timeout counter 0. All registered outputs are 0: memReqOut, memWeOut, memAddrOut, memWDataOut, WB_ENOut, WB_DestOut, WB_ValueOut, errOut. freezeOut is forced 0 while rst = 1.
- Reset during WAIT abandons the access. memReqOut is 0 from the next cycle, and no writeback occurs.
- States: IDLE and WAIT.
- IDLE, no memory op (MEM_R_ENIn = MEM_W_ENIn = 0): pass-through with 1-cycle latency. At the edge, WB_ENOut <= WB_ENIn, WB_DestOut <= DestIn, WB_ValueOut <= ALU_ResIn. freezeOut = 0.
- IDLE, load or store:
  - freezeOut = 1 combinationally in the same cycle.
  - At the edge: go to WAIT; memReqOut <= 1; memWeOut <= MEM_W_ENIn; memAddrOut <= ((ALU_ResIn - ADDR_BASE) mod 2^N) >> 2, truncated to MEM_ADDR_W; memWDataOut <= Val_RmIn; latch DestIn and WB_ENIn internally; WB_ENOut <= 0 (bubble).
  - Address bits [1:0] are ignored; no alignment fault is raised.
  - If both MEM_R_ENIn and MEM_W_ENIn are 1, the access is a store.
- WAIT:
  - memReqOut, memWeOut, memAddrOut and memWDataOut hold stable. Inputs from the upstream stage are ignored.
  - WB_ENOut = 0 every cycle until completion.
  - freezeOut = !memAckIn.
- WAIT with memAckIn = 1, at the edge: go to IDLE; memReqOut <= 0; counter <= 0.
  - Load: WB_ENOut <= latched WB_EN, WB_DestOut <= latched Dest, WB_ValueOut <= memRDataIn.
  - Store: WB_ENOut <= 0.
  - The upstream pipeline advances on this same edge, because freezeOut was low in the ack cycle.
- Timeout:
  - The counter increments each WAIT cycle without ack.
  - When the counter reaches TIMEOUT - 1 with no ack: at the edge, go to IDLE; memReqOut <= 0; errOut <= 1 (sticky until rst); WB_ENOut <= 0. freezeOut = 0 in that cycle.
  - Ack in the same cycle as timeout expiry: ack wins, errOut is unchanged.
- memAckIn while in IDLE is ignored.
- Back-to-back memory ops: each costs at least 2 cycles (IDLE issue + WAIT ack). No pipelining of requests.
- WB outputs are valid for exactly one cycle per retired instruction. WB_ENOut is never 1 for stores or timed-out accesses.

Test Plan:
- ALU op, WB_ENIn=1, DestIn=3, ALU_ResIn=0x55 → next cycle WB_ENOut=1, WB_DestOut=3, WB_ValueOut=0x55; freezeOut=0 throughout.
- Load ALU_ResIn=1032, DestIn=5, memory acks 3 cycles after req with memRDataIn=0xDEADBEEF → memAddrOut=2, memWeOut=0, freezeOut=1 until the ack cycle; the cycle after ack WB_ENOut=1, WB_DestOut=5, WB_ValueOut=0xDEADBEEF.
- Store ALU_ResIn=1028, Val_RmIn=0x1234, ack after 1 WAIT cycle → memAddrOut=1, memWeOut=1, memWDataOut=0x1234; WB_ENOut stays 0.
- Load with memAckIn never asserted, TIMEOUT=4 → memReqOut high for 4 cycles then 0; errOut=1 and stays 1; freezeOut drops; WB_ENOut=0.
- Ack asserted on the exact timeout cycle → normal writeback, errOut=0. Separately: rst asserted during WAIT → next cycle memReqOut=0, WB_ENOut=0, state IDLE; a subsequent ALU op passes through normally.
